// File: rtl/const_stream_gen.sv
// const_stream_gen: multi-channel stochastic constant generator.
// One shared maximal-length Fibonacci LFSR drives every channel. Channel c
// compares the LFSR state rotated left by c bits against its active value,
// so each frame of 2^WIDTH-1 enabled cycles carries exactly 'active' ones.
// Per-channel values are loaded through a valid/ready port.
//
// Optional feature macro: CONST_STREAM_SYNC_LOAD_EN
//   defined   : loads are staged in a per-channel pending register and
//               committed together on the last enabled edge of a frame.
//   undefined : loads write the active value directly (load_ready tied 1).
module const_stream_gen #(
  parameter int          WIDTH     = 12,
  parameter int          CHANNELS  = 4,
  parameter int unsigned SEED      = 1,
  parameter int unsigned PROB_INIT = 0,
  localparam int         CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CW-1:0]       load_chan,
  input  logic [WIDTH-1:0]    load_value,
  output logic [CHANNELS-1:0] y,
  output logic                frame_start
);

  localparam int unsigned NCH = CHANNELS;

  // Tap masks (0-based bit positions) for the supported widths.
  function automatic logic [15:0] tap_mask(input int w);
    logic [15:0] m;
    m = '0;
    case (w)
      8:       m = 16'h00B8;  // taps 8,6,5,4
      10:      m = 16'h0240;  // taps 10,7
      12:      m = 16'h0829;  // taps 12,6,4,1
      16:      m = 16'hD008;  // taps 16,15,13,4
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [15:0]      TAPS16  = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS    = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V  = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] PINIT_V = WIDTH'(PROB_INIT);

  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [WIDTH-1:0]    lfsr_step;
  logic [CHANNELS-1:0] y_q, y_d;
  logic                frame_start_q, frame_start_d;
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [CHANNELS-1:0] chan_sel;
  logic [2*WIDTH-1:0]  dbl;

`ifdef CONST_STREAM_SYNC_LOAD_EN
  logic [WIDTH-1:0]    pending_q [CHANNELS];
  logic [WIDTH-1:0]    pending_d [CHANNELS];
  logic [CHANNELS-1:0] pend_v_q, pend_v_d;
  logic                commit;
`endif

  assign y           = y_q;
  assign frame_start = frame_start_q;

  // LFSR successor state and hold when not enabled.
  always_comb begin
    lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    lfsr_d    = en ? lfsr_step : lfsr_q;
  end

  // One-hot decode of the load target; out-of-range channels decode to none.
  always_comb begin
    chan_sel = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      chan_sel[c] = (load_chan == CW'(c));
    end
  end

  // Stream bits: compare each rotated LFSR view with the channel's value.
  always_comb begin
    y_d           = y_q;
    frame_start_d = 1'b0;
    dbl           = '0;
    if (en) begin
      frame_start_d = (lfsr_q == SEED_V);
      for (int unsigned c = 0; c < NCH; c++) begin
        dbl    = {lfsr_q, lfsr_q} << c;
        y_d[c] = (dbl[2*WIDTH-1:WIDTH] <= active_q[c]);
      end
    end
  end

`ifdef CONST_STREAM_SYNC_LOAD_EN
  // Ready only when the target channel has no staged value; never from load_valid.
  assign load_ready = ~|(chan_sel & pend_v_q);

  // Commit happens on the edge whose LFSR successor is SEED, i.e. the last
  // enabled bit of a frame, so the new value covers the next frame entirely.
  assign commit = en && (lfsr_step == SEED_V);

  // Commit staged values first, then stage any load accepted on this edge so
  // that a load coinciding with the commit waits for the following boundary.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (commit) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (pend_v_q[c]) begin
          active_d[c] = pending_q[c];
          pend_v_d[c] = 1'b0;
        end
      end
    end
    if (load_valid && load_ready) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (chan_sel[c]) begin
          pending_d[c] = load_value;
          pend_v_d[c]  = 1'b1;
        end
      end
    end
  end

  // Staging registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_q <= '{default: '0};
      pend_v_q  <= '0;
    end else begin
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
    end
  end
`else
  assign load_ready = 1'b1;

  // Direct write of the active value on the acceptance edge.
  always_comb begin
    active_d = active_q;
    if (load_valid) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (chan_sel[c]) begin
          active_d[c] = load_value;
        end
      end
    end
  end
`endif

  // Core state: LFSR, active values, registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfsr_q        <= SEED_V;
      active_q      <= '{default: PINIT_V};
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      active_q      <= active_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_const_stream_gen.sv
// Directed bench for const_stream_gen (WIDTH=12, CHANNELS=4, SEED=1, PROB_INIT=0).
// Exercises the sync-load build when CONST_STREAM_SYNC_LOAD_EN is defined,
// otherwise the direct-load build.
`timescale 1ns/1ps
module tb_const_stream_gen;

  localparam int          FRAME  = 4095;
  localparam logic [11:0] SEED_V = 12'd1;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [1:0]  load_chan = '0;
  logic [11:0] load_value = '0;
  logic [3:0]  y;
  logic        frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [11:0] mstate;
  int          mact [4];
`ifdef CONST_STREAM_SYNC_LOAD_EN
  int          mpend [4];
  bit          mpv [4];
`endif
  logic [3:0]  exp_y;
  int          cnt [4];
  int          en_cycles;
  int          fs_cnt;
  int          fs_at [2];
  int          bad_y, bad_fs, bad_rdy;

  const_stream_gen #(
    .WIDTH(12),
    .CHANNELS(4),
    .SEED(1),
    .PROB_INIT(0)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .en(en),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_chan(load_chan),
    .load_value(load_value),
    .y(y),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lstep(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

  function automatic logic [11:0] rotl(input logic [11:0] s, input int c);
    logic [23:0] d;
    d = {s, s} << c;
    return d[23:12];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mstate    = SEED_V;
    mact      = '{default: 0};
`ifdef CONST_STREAM_SYNC_LOAD_EN
    mpend     = '{default: 0};
    mpv       = '{default: 0};
`endif
    exp_y     = '0;
    cnt       = '{default: 0};
    en_cycles = 0;
    fs_cnt    = 0;
    fs_at     = '{default: 0};
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    en = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset y", y, 0);
    chk("reset frame_start", frame_start, 0);
    model_reset();
    n_rst = 1'b1;
  endtask

  // One clock: drive inputs, check ready, clock, check y/frame_start, update model.
  task automatic do_cycle(input bit e, input bit lv, input int lc, input int val);
    logic [3:0] ey;
    bit efs, erdy, acc;
    en = e;
    load_valid = lv;
    load_chan = lc[1:0];
    load_value = val[11:0];
`ifdef CONST_STREAM_SYNC_LOAD_EN
    erdy = !mpv[lc];
`else
    erdy = 1'b1;
`endif
    #1;
    if (load_ready !== erdy) bad_rdy++;
    ey = exp_y;
    if (e) begin
      for (int c = 0; c < 4; c++) ey[c] = (int'(rotl(mstate, c)) <= mact[c]);
    end
    efs = e && (mstate == SEED_V);
    @(posedge clk);
    #1;
    if (y !== ey) bad_y++;
    if (frame_start !== efs) bad_fs++;
    exp_y = ey;
    if (e) begin
      for (int c = 0; c < 4; c++) cnt[c] += int'(y[c]);
    end
    if (frame_start === 1'b1) begin
      if (fs_cnt < 2) fs_at[fs_cnt] = en_cycles + 1;
      fs_cnt++;
    end
    acc = lv && erdy;
`ifdef CONST_STREAM_SYNC_LOAD_EN
    if (e && lstep(mstate) == SEED_V) begin
      for (int c = 0; c < 4; c++) begin
        if (mpv[c]) begin
          mact[c] = mpend[c];
          mpv[c]  = 1'b0;
        end
      end
    end
    if (acc) begin
      mpend[lc] = val;
      mpv[lc]   = 1'b1;
    end
`else
    if (acc) mact[lc] = val;
`endif
    if (e) begin
      mstate = lstep(mstate);
      en_cycles++;
    end
    load_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) do_cycle(1'b1, 1'b0, 0, 0);
  endtask

  // One frame of pseudo-random en; optional load at en-position ld_pos and
  // optional second load on the frame's last enabled (commit) edge.
  task automatic rand_frame(input int ld_pos, input int ld_chan, input int ld_val,
                            input int b_chan, input int b_val);
    int k;
    k = 0;
    while (k < FRAME) begin
      bit e;
      e = ($urandom_range(0, 2) != 0);
      if (k == ld_pos || (k == FRAME - 1 && b_chan >= 0)) e = 1'b1;
      if (e && k == ld_pos) do_cycle(1'b1, 1'b1, ld_chan, ld_val);
      else if (e && k == FRAME - 1 && b_chan >= 0) do_cycle(1'b1, 1'b1, b_chan, b_val);
      else do_cycle(e, 1'b0, 0, 0);
      if (e) k++;
    end
  endtask

  task automatic chk_counts(input string tag, input int e0, input int e1, input int e2, input int e3);
    int ev [4];
    ev = '{e0, e1, e2, e3};
    for (int c = 0; c < 4; c++) chk($sformatf("%s ch%0d count", tag, c), cnt[c], ev[c]);
    cnt = '{default: 0};
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " y bit errors"}, bad_y, 0);
    chk({tag, " frame_start errors"}, bad_fs, 0);
    chk({tag, " load_ready errors"}, bad_rdy, 0);
    bad_y = 0;
    bad_fs = 0;
    bad_rdy = 0;
  endtask

  task automatic check_ready(input string tag, input int ch, input int expv);
    load_chan = ch[1:0];
    #1;
    chk(tag, load_ready, expv);
  endtask

  initial begin
    bad_y = 0;
    bad_fs = 0;
    bad_rdy = 0;
    model_reset();

    // PROB_INIT=0 over two frames: all zeros, frame_start at cycles 1 and 4096
    do_reset();
    check_ready("ready after reset", 0, 1);
    run(2 * FRAME);
    chk("frame_start pulses", fs_cnt, 2);
    chk("frame_start first cycle", fs_at[0], 1);
    chk("frame_start second cycle", fs_at[1], 4096);
    chk_counts("zero frames", 0, 0, 0, 0);
    chk_model("zero frames");

`ifdef CONST_STREAM_SYNC_LOAD_EN
    // Loads before the first frame commit at its end
    do_reset();
    do_cycle(1'b0, 1'b1, 0, 1000);
    do_cycle(1'b0, 1'b1, 1, 4095);
    do_cycle(1'b0, 1'b1, 2, 0);
    do_cycle(1'b0, 1'b1, 3, 2048);
    check_ready("ready ch0 while pending", 0, 0);
    run(FRAME);
    chk_counts("sync f1", 0, 0, 0, 0);
    run(FRAME);
    chk_counts("sync f2", 1000, 4095, 0, 2048);
    run(FRAME);
    chk_counts("sync f3", 1000, 4095, 0, 2048);
    chk_model("sync initial loads");

    // Mid-frame load to ch1, then a rejected second load
    run(999);
    do_cycle(1'b1, 1'b1, 1, 500);
    check_ready("ready ch1 pending", 1, 0);
    check_ready("ready ch0 free", 0, 1);
    do_cycle(1'b1, 1'b1, 1, 7);
    run(FRAME - 1001);
    chk_counts("sync f4", 1000, 4095, 0, 2048);
    check_ready("ready ch1 after commit", 1, 1);
    run(FRAME);
    chk_counts("sync f5", 1000, 500, 0, 2048);
    chk_model("sync mid-frame load");

    // Random en; ch3 load mid-frame, ch2 load on the commit edge
    rand_frame(1000, 3, 100, 2, 300);
    check_ready("ready ch2 boundary load pending", 2, 0);
    chk_counts("sync f6", 1000, 500, 0, 2048);
    rand_frame(-1, 0, 0, -1, 0);
    chk_counts("sync f7", 1000, 500, 0, 100);
    run(FRAME);
    chk_counts("sync f8", 1000, 500, 300, 100);
    chk_model("sync random en");

    // Reset mid-frame with a pending load
    run(500);
    do_cycle(1'b1, 1'b1, 0, 3000);
    #1;
    n_rst = 1'b0;
    #1;
    chk("async reset y", y, 0);
    chk("async reset frame_start", frame_start, 0);
    check_ready("ready ch0 after reset", 0, 1);
    do_reset();
    run(FRAME);
    chk_counts("post-reset f1", 0, 0, 0, 0);
    run(FRAME);
    chk_counts("post-reset f2", 0, 0, 0, 0);
    chk_model("sync reset");
`else
    // Direct load of 4095 on cycle 100 of a value-0 frame
    run(99);
    do_cycle(1'b1, 1'b1, 0, 4095);
    chk("y0 on load cycle", y[0], 0);
    do_cycle(1'b1, 1'b0, 0, 0);
    chk("y0 cycle after load", y[0], 1);
    run(FRAME - 101);
    chk_counts("direct load frame", 3995, 0, 0, 0);
    check_ready("ready tied high", 1, 1);

    // Loads with en low at the frame boundary take effect for the whole frame
    do_cycle(1'b0, 1'b1, 1, 1234);
    do_cycle(1'b0, 1'b1, 2, 1);
    do_cycle(1'b0, 1'b1, 3, 4094);
    run(FRAME);
    chk_counts("direct f2", 4095, 1234, 1, 4094);
    rand_frame(-1, 0, 0, -1, 0);
    chk_counts("direct random en", 4095, 1234, 1, 4094);
    chk_model("direct loads");

    // Reset mid-frame returns to PROB_INIT
    run(500);
    #1;
    n_rst = 1'b0;
    #1;
    chk("async reset y", y, 0);
    chk("async reset frame_start", frame_start, 0);
    do_reset();
    run(FRAME);
    chk_counts("post-reset frame", 0, 0, 0, 0);
    chk_model("direct reset");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
